// File: rtl/sdram_ch2_arbiter_pkg.sv
// Purpose: shared types for the SDRAM channel-2 arbiter (FSM states, requester ids, address width).
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package nes_mem_pkg;

  localparam int SDRAM_AW = 25;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_ARM,
    S_WAIT,
    S_RESP
  } arb_state_t;

  typedef enum logic {
    REQ_SS,
    REQ_BK
  } req_id_t;

endpackage

// File: rtl/sdram_ch2_arbiter_if.sv
// Purpose: bundles savestate, backup-RAM and SDRAM channel-2 signals around the arbiter.
// Latency: wiring only.
// Backpressure: expressed through ss_busy/bk_busy and drop, not through this bundle.
interface sdram_ch2_arbiter_if
  import nes_mem_pkg::*;
#(
  parameter int BK_AW = 18
);

  logic                ss_mode;
  logic [SDRAM_AW-1:0] ss_addr;
  logic [7:0]          ss_din;
  logic                ss_rd;
  logic                ss_wr;
  logic [7:0]          ss_dout;
  logic                ss_done;
  logic                ss_busy;

  logic [BK_AW-1:0]    bk_addr;
  logic [7:0]          bk_din;
  logic                bk_rd;
  logic                bk_wr;
  logic [7:0]          bk_dout;
  logic                bk_done;
  logic                bk_busy;

  logic [SDRAM_AW-1:0] ch2_addr;
  logic [7:0]          ch2_din;
  logic                ch2_rd;
  logic                ch2_wr;
  logic [7:0]          ch2_dout;
  logic                ch2_busy;

  logic                drop;

  // Requesters and the SDRAM controller together form the master side.
  modport master (
    output ss_mode, ss_addr, ss_din, ss_rd, ss_wr,
    output bk_addr, bk_din, bk_rd, bk_wr,
    output ch2_dout, ch2_busy,
    input  ss_dout, ss_done, ss_busy,
    input  bk_dout, bk_done, bk_busy,
    input  ch2_addr, ch2_din, ch2_rd, ch2_wr,
    input  drop
  );

  // The arbiter itself.
  modport slave (
    input  ss_mode, ss_addr, ss_din, ss_rd, ss_wr,
    input  bk_addr, bk_din, bk_rd, bk_wr,
    input  ch2_dout, ch2_busy,
    output ss_dout, ss_done, ss_busy,
    output bk_dout, bk_done, bk_busy,
    output ch2_addr, ch2_din, ch2_rd, ch2_wr,
    output drop
  );

endinterface

// File: rtl/sdram_ch2_arbiter_req_slot.sv
// Purpose: single-entry pending slot for one requester (capture, hold, full flag, drop detect).
// Latency: request captured on the edge ending its pulse cycle; full visible the next cycle.
// Backpressure: a request while full (and not being cleared) is discarded and flagged on drop.
module req_slot #(
  parameter int AW = 25
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    din,
  input  logic          rd,
  input  logic          wr,
  input  logic          clr,
  output logic          full,
  output logic [AW-1:0] addr_q,
  output logic [7:0]    din_q,
  output logic          is_wr,
  output logic          drop
);

  logic req;
  logic take;

  // A clearing slot may be refilled in the same cycle; rd+wr together counts as a write.
  assign req  = rd | wr;
  assign take = req & (~full | clr);
  assign drop = req & full & ~clr;

  // Hold the accepted request until the arbiter clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full   <= 1'b0;
      addr_q <= '0;
      din_q  <= '0;
      is_wr  <= 1'b0;
    end else if (take) begin
      full   <= 1'b1;
      addr_q <= addr;
      din_q  <= din;
      is_wr  <= wr;
    end else if (clr) begin
      full   <= 1'b0;
    end
  end

endmodule

// File: rtl/sdram_ch2_arbiter.sv
// Purpose: shares SDRAM channel 2 between the savestate engine and the backup-RAM path.
// Latency: request cycle 0 -> ch2 pulse cycle 2; done one cycle after ch2_busy is first seen low.
// Backpressure: one pending request per side; extra requests are dropped with a drop pulse.
module sdram_ch2_arbiter
  import nes_mem_pkg::*;
#(
  parameter int                        BK_AW   = 18,
  parameter logic [SDRAM_AW-BK_AW-1:0] BK_BASE = 7'b0001111,
  parameter int                        ARM_CYC = 4
) (
  input logic                clk,
  input logic                reset,
  sdram_ch2_arbiter_if.slave bus
);

  localparam int ACW = $clog2(ARM_CYC + 1);

  arb_state_t          state;
  req_id_t             grant;
  logic [ACW-1:0]      arm_cnt;

  logic                ss_full, bk_full;
  logic                ss_is_wr, bk_is_wr;
  logic                ss_drop, bk_drop;
  logic                ss_clr, bk_clr;
  logic [SDRAM_AW-1:0] ss_addr_q;
  logic [BK_AW-1:0]    bk_addr_q;
  logic [7:0]          ss_din_q, bk_din_q;
  logic                pick_ss;
  logic                finish;

  logic [SDRAM_AW-1:0] ch2_addr_r;
  logic [7:0]          ch2_din_r, ss_dout_r, bk_dout_r;
  logic                ch2_rd_r, ch2_wr_r, ss_done_r, bk_done_r, drop_r;

  req_slot #(.AW(SDRAM_AW)) u_ss_slot (
    .clk(clk), .reset(reset),
    .addr(bus.ss_addr), .din(bus.ss_din), .rd(bus.ss_rd), .wr(bus.ss_wr), .clr(ss_clr),
    .full(ss_full), .addr_q(ss_addr_q), .din_q(ss_din_q), .is_wr(ss_is_wr), .drop(ss_drop)
  );

  req_slot #(.AW(BK_AW)) u_bk_slot (
    .clk(clk), .reset(reset),
    .addr(bus.bk_addr), .din(bus.bk_din), .rd(bus.bk_rd), .wr(bus.bk_wr), .clr(bk_clr),
    .full(bk_full), .addr_q(bk_addr_q), .din_q(bk_din_q), .is_wr(bk_is_wr), .drop(bk_drop)
  );

  // Slot of the granted side is released during RESP; savestate wins ties only while saving.
  assign ss_clr  = (state == S_RESP) && (grant == REQ_SS);
  assign bk_clr  = (state == S_RESP) && (grant == REQ_BK);
  assign pick_ss = ss_full && (!bk_full || bus.ss_mode);
  // Completion: busy seen low in WAIT, or ARM_CYC arm cycles passed with no busy at all.
  assign finish  = ((state == S_ARM) && (arm_cnt == ACW'(ARM_CYC))) ||
                   ((state == S_WAIT) && !bus.ch2_busy);

  // Grant, issue and completion sequencing with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      grant      <= REQ_SS;
      arm_cnt    <= '0;
      ch2_addr_r <= '0;
      ch2_din_r  <= '0;
      ch2_rd_r   <= 1'b0;
      ch2_wr_r   <= 1'b0;
      ss_dout_r  <= '0;
      bk_dout_r  <= '0;
      ss_done_r  <= 1'b0;
      bk_done_r  <= 1'b0;
      drop_r     <= 1'b0;
    end else begin
      ch2_rd_r  <= 1'b0;
      ch2_wr_r  <= 1'b0;
      ss_done_r <= 1'b0;
      bk_done_r <= 1'b0;
      drop_r    <= ss_drop | bk_drop;
      case (state)
        S_IDLE: begin
          if (ss_full || bk_full) begin
            state <= S_ISSUE;
            if (pick_ss) begin
              grant      <= REQ_SS;
              ch2_addr_r <= ss_addr_q;
              ch2_din_r  <= ss_din_q;
              ch2_wr_r   <= ss_is_wr;
              ch2_rd_r   <= ~ss_is_wr;
            end else begin
              grant      <= REQ_BK;
              ch2_addr_r <= {BK_BASE, bk_addr_q};
              ch2_din_r  <= bk_din_q;
              ch2_wr_r   <= bk_is_wr;
              ch2_rd_r   <= ~bk_is_wr;
            end
          end
        end
        S_ISSUE: begin
          arm_cnt <= '0;
          state   <= S_ARM;
        end
        S_ARM: begin
          arm_cnt <= arm_cnt + 1'b1;
          if (bus.ch2_busy) state <= S_WAIT;
        end
        S_WAIT: ;
        S_RESP: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (finish) begin
        state <= S_RESP;
        if (grant == REQ_SS) begin
          ss_done_r <= 1'b1;
          if (!ss_is_wr) ss_dout_r <= bus.ch2_dout;
        end else begin
          bk_done_r <= 1'b1;
          if (!bk_is_wr) bk_dout_r <= bus.ch2_dout;
        end
      end
    end
  end

  assign bus.ch2_addr = ch2_addr_r;
  assign bus.ch2_din  = ch2_din_r;
  assign bus.ch2_rd   = ch2_rd_r;
  assign bus.ch2_wr   = ch2_wr_r;
  assign bus.ss_dout  = ss_dout_r;
  assign bus.ss_done  = ss_done_r;
  assign bus.ss_busy  = ss_full;
  assign bus.bk_dout  = bk_dout_r;
  assign bus.bk_done  = bk_done_r;
  assign bus.bk_busy  = bk_full;
  assign bus.drop     = drop_r;

endmodule

// File: tb/tb_sdram_ch2_arbiter.sv
// Purpose: directed checks of sdram_ch2_arbiter grant order, timing, drop and reset.
// Latency: cycle k of each test is the k-th clock after the request pulse (cycle 0).
// Backpressure: a small SDRAM model holds ch2_busy for lat cycles after each issue.
module tb_sdram_ch2_arbiter;
  import nes_mem_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sdram_ch2_arbiter_if #(.BK_AW(18)) bus ();

  sdram_ch2_arbiter #(.BK_AW(18), .BK_BASE(7'b0001111), .ARM_CYC(4)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int k, lat, mdl_left;
  int n_rd, n_wr, n_ss, n_bk, n_drop;
  int rd_at, wr_at, ss_at, bk_at, drop_at, bkb_first, bkb_last;
  logic [24:0] iss_addr;
  logic [7:0]  iss_din, ss_dout_at, bk_dout_at, dval;
  bit dfix;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clr_log();
    k = 0; mdl_left = 0; bus.ch2_busy = 1'b0;
    n_rd = 0; n_wr = 0; n_ss = 0; n_bk = 0; n_drop = 0;
    rd_at = -1; wr_at = -1; ss_at = -1; bk_at = -1; drop_at = -1;
    bkb_first = -1; bkb_last = -1;
    iss_addr = '0; iss_din = '0; ss_dout_at = '0; bk_dout_at = '0;
  endtask

  // One clock: drive the SDRAM model, sample mid-cycle, advance, drop request pulses.
  task automatic step();
    bus.ch2_busy = (mdl_left > 0);
    if (mdl_left > 0) mdl_left--;
    #4;
    if (bus.ch2_rd || bus.ch2_wr) begin
      if (bus.ch2_rd) begin n_rd++; if (rd_at < 0) rd_at = k; end
      if (bus.ch2_wr) begin n_wr++; if (wr_at < 0) wr_at = k; end
      iss_addr = bus.ch2_addr;
      iss_din  = bus.ch2_din;
      mdl_left = lat;
      bus.ch2_dout = dfix ? dval : bus.ch2_addr[7:0];
    end
    if (bus.ss_done) begin n_ss++; if (ss_at < 0) ss_at = k; ss_dout_at = bus.ss_dout; end
    if (bus.bk_done) begin n_bk++; if (bk_at < 0) bk_at = k; bk_dout_at = bus.bk_dout; end
    if (bus.drop) begin n_drop++; if (drop_at < 0) drop_at = k; end
    if (bus.bk_busy) begin if (bkb_first < 0) bkb_first = k; bkb_last = k; end
    @(posedge clk); #1;
    bus.ss_rd = 1'b0; bus.ss_wr = 1'b0; bus.bk_rd = 1'b0; bus.bk_wr = 1'b0;
    k++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk_rst(input string tag);
    chk_eq({tag, "_addr"}, {7'd0, bus.ch2_addr}, 32'h0);
    chk_eq({tag, "_ctl"}, {25'd0, bus.ch2_rd, bus.ch2_wr, bus.ss_busy, bus.bk_busy,
                           bus.ss_done, bus.bk_done, bus.drop}, 32'h0);
    chk_eq({tag, "_data"}, {8'd0, bus.ch2_din, bus.ss_dout, bus.bk_dout}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.ss_mode = 1'b0; bus.ss_addr = '0; bus.ss_din = '0; bus.ss_rd = 1'b0; bus.ss_wr = 1'b0;
    bus.bk_addr = '0; bus.bk_din = '0; bus.bk_rd = 1'b0; bus.bk_wr = 1'b0;
    bus.ch2_dout = '0; bus.ch2_busy = 1'b0;
    lat = 0; dfix = 1'b0; dval = '0;
    clr_log();
    #2;
    chk_rst("reset");
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Backup write: busy cycles 3..6, done in cycle 8, address {BK_BASE, addr}.
    clr_log(); lat = 4;
    bus.bk_addr = 18'h00012; bus.bk_din = 8'hA5; bus.bk_wr = 1'b1;
    run(12);
    chk_eq("bkwr_wr_cyc", wr_at, 2);
    chk_eq("bkwr_n_wr", n_wr, 1);
    chk_eq("bkwr_n_rd", n_rd, 0);
    chk_eq("bkwr_addr", iss_addr, 32'h03C0012);
    chk_eq("bkwr_din", iss_din, 8'hA5);
    chk_eq("bkwr_done_cyc", bk_at, 8);
    chk_eq("bkwr_n_done", n_bk, 1);
    chk_eq("bkwr_ss_done", n_ss, 0);
    chk_eq("bkwr_dout_kept", bk_dout_at, 8'h00);
    chk_eq("bkwr_busy_first", bkb_first, 1);
    chk_eq("bkwr_busy_last", bkb_last, 8);
    chk_eq("bkwr_drop", n_drop, 0);

    // Savestate read returns ch2_dout at busy fall.
    clr_log(); lat = 2; dfix = 1'b1; dval = 8'h3C; bus.ss_mode = 1'b1;
    bus.ss_addr = 25'h0123456; bus.ss_rd = 1'b1;
    run(10);
    chk_eq("ssrd_rd_cyc", rd_at, 2);
    chk_eq("ssrd_addr", iss_addr, 32'h0123456);
    chk_eq("ssrd_done_cyc", ss_at, 6);
    chk_eq("ssrd_dout", ss_dout_at, 8'h3C);
    chk_eq("ssrd_bk_done", n_bk, 0);

    // Simultaneous reads, ss_mode=1: savestate first.
    clr_log(); lat = 2; dfix = 1'b0; bus.ss_mode = 1'b1;
    bus.ss_addr = 25'h0000144; bus.ss_rd = 1'b1;
    bus.bk_addr = 18'h00077;   bus.bk_rd = 1'b1;
    run(16);
    chk_eq("pri1_ss_cyc", ss_at, 6);
    chk_eq("pri1_bk_cyc", bk_at, 12);
    chk_eq("pri1_ss_dout", ss_dout_at, 8'h44);
    chk_eq("pri1_bk_dout", bk_dout_at, 8'h77);

    // Same with ss_mode=0: backup first.
    clr_log(); lat = 2; bus.ss_mode = 1'b0;
    bus.ss_addr = 25'h0000155; bus.ss_rd = 1'b1;
    bus.bk_addr = 18'h00088;   bus.bk_rd = 1'b1;
    run(16);
    chk_eq("pri0_bk_cyc", bk_at, 6);
    chk_eq("pri0_ss_cyc", ss_at, 12);
    chk_eq("pri0_ss_dout", ss_dout_at, 8'h55);
    chk_eq("pri0_bk_dout", bk_dout_at, 8'h88);

    // Second backup read while busy is dropped.
    clr_log(); lat = 2;
    bus.bk_addr = 18'h00010; bus.bk_rd = 1'b1;
    run(3);
    bus.bk_addr = 18'h00020; bus.bk_rd = 1'b1;
    run(9);
    chk_eq("drop_n", n_drop, 1);
    chk_eq("drop_cyc", drop_at, 4);
    chk_eq("drop_n_rd", n_rd, 1);
    chk_eq("drop_n_done", n_bk, 1);

    // Request from the granted side in its RESP cycle is accepted.
    clr_log(); lat = 1;
    bus.bk_addr = 18'h00030; bus.bk_din = 8'h11; bus.bk_wr = 1'b1;
    run(5);
    bus.bk_addr = 18'h00031; bus.bk_rd = 1'b1;
    run(10);
    chk_eq("resp_done1", bk_at, 5);
    chk_eq("resp_rd_cyc", rd_at, 7);
    chk_eq("resp_drop", n_drop, 0);
    chk_eq("resp_n_done", n_bk, 2);

    // ch2_busy never rises: timeout completion in cycle 8.
    clr_log(); lat = 0;
    bus.ss_addr = 25'h0000200; bus.ss_din = 8'h5A; bus.ss_wr = 1'b1;
    run(12);
    chk_eq("tmo_wr_cyc", wr_at, 2);
    chk_eq("tmo_done_cyc", ss_at, 8);
    chk_eq("tmo_n_done", n_ss, 1);

    // Reset during WAIT abandons the transfer.
    clr_log(); lat = 6;
    bus.bk_addr = 18'h00040; bus.bk_rd = 1'b1;
    run(5);
    reset = 1'b1;
    #4;
    chk_rst("midrst");
    @(posedge clk); #1;
    reset = 1'b0;
    clr_log();
    run(10);
    chk_eq("midrst_no_done", n_bk + n_ss, 0);
    chk_eq("midrst_no_issue", n_rd + n_wr, 0);

    // Normal service after the abandoned transfer.
    clr_log(); lat = 1;
    bus.bk_addr = 18'h00050; bus.bk_din = 8'h77; bus.bk_wr = 1'b1;
    run(8);
    chk_eq("post_wr_cyc", wr_at, 2);
    chk_eq("post_done_cyc", bk_at, 5);
    chk_eq("post_n_done", n_bk, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
